// File: rtl/camera_ingest_pkg.sv
// Shared constants and elaboration helpers for the camera stripe ingester.
// Exports: BLOCK_DIM, BLOCK_SIZE, width_of(), ebr_fits().
package camera_ingest_pkg;

    localparam int BLOCK_DIM  = 8;
    localparam int BLOCK_SIZE = 64;

    // Bit width able to index n items, never narrower than 1.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when every block slot of one line fits in one output RAM.
    function automatic bit ebr_fits(
        input int img_w,
        input int num_ebrs,
        input int addr_w
    );
        int blocks;
        int slots;
        blocks = img_w / BLOCK_DIM;
        slots  = (blocks + num_ebrs - 1) / num_ebrs;
        return (slots * BLOCK_SIZE) <= (1 << addr_w);
    endfunction

endpackage

// File: rtl/cam_input_sync.sv
// Synchronises the raw camera bus into the system clock domain.
// Ports: cam_* in; registered edge strobes, synced levels and data out.
module cam_input_sync
    import camera_ingest_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             cam_pixclk,
    input  logic [PIX_W-1:0] cam_pixdata,
    input  logic             cam_hsync,
    input  logic             cam_vsync,
    output logic             pix_edge,
    output logic             hsync_rise,
    output logic             hsync_fall,
    output logic             vsync_rise,
    output logic             vsync_fall,
    output logic             hsync_lvl,
    output logic             vsync_lvl,
    output logic [PIX_W-1:0] data
);

    // Control bits packed as {pixclk, hsync, vsync}.
    logic [2:0]       ctl_s1;
    logic [2:0]       ctl_s2;
    logic [2:0]       ctl_h;
    logic [PIX_W-1:0] dat_s1;
    logic [PIX_W-1:0] dat_s2;
    logic [1:0]       warm;
    logic             primed;

    // Edges are masked until the pipeline holds real samples, so a
    // level already high when reset lifts is not mistaken for an edge.
    assign primed = (warm == 2'd3);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ctl_s1     <= '0;
            ctl_s2     <= '0;
            ctl_h      <= '0;
            dat_s1     <= '0;
            dat_s2     <= '0;
            warm       <= '0;
            pix_edge   <= 1'b0;
            hsync_rise <= 1'b0;
            hsync_fall <= 1'b0;
            vsync_rise <= 1'b0;
            vsync_fall <= 1'b0;
            hsync_lvl  <= 1'b0;
            vsync_lvl  <= 1'b0;
            data       <= '0;
        end else begin
            ctl_s1 <= {cam_pixclk, cam_hsync, cam_vsync};
            ctl_s2 <= ctl_s1;
            ctl_h  <= ctl_s2;
            dat_s1 <= cam_pixdata;
            dat_s2 <= dat_s1;
            if (!primed) begin
                warm <= warm + 2'd1;
            end
            pix_edge   <= primed & ctl_s2[2] & ~ctl_h[2];
            hsync_rise <= primed & ctl_s2[1] & ~ctl_h[1];
            hsync_fall <= primed & ~ctl_s2[1] & ctl_h[1];
            vsync_rise <= primed & ctl_s2[0] & ~ctl_h[0];
            vsync_fall <= primed & ~ctl_s2[0] & ctl_h[0];
            hsync_lvl  <= ctl_s2[1];
            vsync_lvl  <= ctl_s2[0];
            data       <= dat_s2;
        end
    end

endmodule

// File: rtl/camera_stripe_ingester.sv
// Reorders 8-line camera stripes into 8x8 blocks over a ring of banks.
// Ports: cam_* in; out_* RAM write port; stripe_* consumer handshake.
module camera_stripe_ingester
    import camera_ingest_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int NUM_EBRS   = 5,
    parameter int NUM_BANKS  = 2,
    parameter int EBR_ADDR_W = 9,
    localparam int BW        = width_of(NUM_BANKS),
    localparam int EW        = width_of(NUM_EBRS)
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  cam_pixclk,
    input  logic [PIX_W-1:0]      cam_pixdata,
    input  logic                  cam_hsync,
    input  logic                  cam_vsync,
    output logic [BW-1:0]         out_bank,
    output logic [EW-1:0]         out_ebr_sel,
    output logic [EBR_ADDR_W-1:0] out_addr,
    output logic [PIX_W-1:0]      out_pixval,
    output logic                  out_wren,
    output logic                  stripe_valid,
    output logic [BW-1:0]         stripe_bank,
    output logic                  stripe_last,
    input  logic                  stripe_release,
    output logic                  frame_start,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int CW = width_of(IMG_W + 1);
    localparam int RW = width_of(IMG_H + 1);

    if (IMG_W % BLOCK_DIM != 0) begin : g_bad_w
        $error("IMG_W must be a multiple of 8");
    end
    if (IMG_H % BLOCK_DIM != 0) begin : g_bad_h
        $error("IMG_H must be a multiple of 8");
    end
    if (!ebr_fits(IMG_W, NUM_EBRS, EBR_ADDR_W)) begin : g_bad_a
        $error("EBR_ADDR_W too small for IMG_W/NUM_EBRS");
    end
    if (NUM_BANKS < 2) begin : g_bad_b
        $error("NUM_BANKS must be at least 2");
    end

    logic             pix_edge;
    logic             hs_rise;
    logic             hs_fall;
    logic             vs_rise;
    logic             vs_fall;
    logic             hs_lvl;
    logic             vs_lvl;
    logic [PIX_W-1:0] pix;

    cam_input_sync #(
        .PIX_W(PIX_W)
    ) u_sync (
        .clock      (clock),
        .nreset     (nreset),
        .cam_pixclk (cam_pixclk),
        .cam_pixdata(cam_pixdata),
        .cam_hsync  (cam_hsync),
        .cam_vsync  (cam_vsync),
        .pix_edge   (pix_edge),
        .hsync_rise (hs_rise),
        .hsync_fall (hs_fall),
        .vsync_rise (vs_rise),
        .vsync_fall (vs_fall),
        .hsync_lvl  (hs_lvl),
        .vsync_lvl  (vs_lvl),
        .data       (pix)
    );

    logic                  armed;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  line_pix;
    logic                  dropped;
    logic [NUM_BANKS-1:0]  full;
    logic [NUM_BANKS-1:0]  last;
    logic [BW-1:0]         wr_ptr;
    logic [BW-1:0]         rd_ptr;

    logic                  accept;
    logic                  stripe_start;
    logic                  rel_fire;
    logic                  wr_busy;
    logic                  drop_now;
    logic                  commit;
    int                    blk;
    logic [EW-1:0]         ebr_n;
    logic [EBR_ADDR_W-1:0] addr_n;
    logic [NUM_BANKS-1:0]  full_n;
    logic [NUM_BANKS-1:0]  last_n;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign stripe_valid = full[rd_ptr];
    assign stripe_bank  = rd_ptr;
    assign stripe_last  = last[rd_ptr];

    always_comb begin
        accept = armed & pix_edge & hs_lvl & vs_lvl
               & (col < CW'(IMG_W))
               & (row < RW'(IMG_H));
        stripe_start = accept & ~line_pix & (row[2:0] == 3'd0);
        rel_fire = stripe_release & full[rd_ptr];
        // A bank released this very cycle is already free.
        wr_busy = full[wr_ptr]
                & ~(rel_fire & (rd_ptr == wr_ptr));
        drop_now = stripe_start ? wr_busy : dropped;
        commit = hs_fall & ~vs_fall & line_pix
               & (row[2:0] == 3'd7) & ~dropped;

        blk    = int'(col >> 3);
        ebr_n  = EW'(blk % NUM_EBRS);
        addr_n = EBR_ADDR_W'((blk / NUM_EBRS) * BLOCK_SIZE
               + int'(row[2:0]) * BLOCK_DIM
               + int'(col[2:0]));

        full_n = full;
        last_n = last;
        if (rel_fire) begin
            full_n[rd_ptr] = 1'b0;
        end
        if (commit) begin
            full_n[wr_ptr] = 1'b1;
            last_n[wr_ptr] = (row == RW'(IMG_H - 1));
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            out_bank    <= '0;
            out_ebr_sel <= '0;
            out_addr    <= '0;
            out_pixval  <= '0;
            out_wren    <= 1'b0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
            armed       <= 1'b0;
            col         <= '0;
            row         <= '0;
            line_pix    <= 1'b0;
            dropped     <= 1'b0;
            full        <= '0;
            last        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            out_wren    <= accept & ~drop_now;
            frame_start <= vs_rise;
            if (accept) begin
                out_bank    <= wr_ptr;
                out_ebr_sel <= ebr_n;
                out_addr    <= addr_n;
                out_pixval  <= pix;
            end

            if (vs_rise) begin
                armed    <= 1'b1;
                col      <= '0;
                row      <= '0;
                line_pix <= 1'b0;
                dropped  <= 1'b0;
            end else if (vs_fall) begin
                // Partial stripe is abandoned; wr_ptr stays put.
                line_pix <= 1'b0;
                dropped  <= 1'b0;
            end else begin
                if (hs_rise) begin
                    col      <= '0;
                    line_pix <= 1'b0;
                end
                if (accept) begin
                    col      <= col + 1'b1;
                    line_pix <= 1'b1;
                end
                if (stripe_start) begin
                    dropped <= wr_busy;
                end
                if (hs_fall && line_pix) begin
                    row      <= row + 1'b1;
                    line_pix <= 1'b0;
                end
            end

            if (stripe_start && wr_busy) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end

            full <= full_n;
            last <= last_n;
            if (commit) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rel_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

endmodule
